// File: rtl/bcd_conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types and constants for the sequential binary-to-BCD
//                conversion controller (digit type, FSM state encoding,
//                double-dabble adjust constants).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

   localparam int NUM_DIGITS = 5;
   localparam int MAX_BIN_W  = 16;
   localparam int ADJ_THRESH = 5;
   localparam int ADJ_ADD    = 3;

   // Scratch register holds all BCD digits side by side.
   localparam int SCR_W = 4 * NUM_DIGITS;
   // Bit counter must be able to hold the largest legal BIN_W.
   localparam int CNT_W = $clog2(MAX_BIN_W + 1);

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_conv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv_ctrl_if
//  Description : Request/result bundle between the measurement logic
//                (master) and the BCD conversion controller (slave).
//  Signals     : start    - conversion request (master -> slave)
//                bin      - unsigned value to convert (master -> slave)
//                busy     - conversion in flight incl. done cycle
//                done     - one-cycle result-valid pulse
//                ONES/TENS/HUNDREDS/TH - latched BCD digits
//                ovf      - latched, value >= 10000
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_conv_ctrl_if
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   bcd_digit_t       ONES;
   bcd_digit_t       TENS;
   bcd_digit_t       HUNDREDS;
   bcd_digit_t       TH;
   logic             ovf;

   modport master (
      output start, bin,
      input  busy, done, ONES, TENS, HUNDREDS, TH, ovf
   );

   modport slave (
      input  start, bin,
      output busy, done, ONES, TENS, HUNDREDS, TH, ovf
   );

endinterface : bcd_conv_ctrl_if
`default_nettype wire

// File: rtl/bcd_conv_ctrl_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Combinational double-dabble adjust cell for one BCD digit:
//                digit_o = (digit_i >= 5) ? digit_i + 3 : digit_i.
//                No carry out; digits never interact.
//  Ports       : digit_i - current 4-bit digit
//                digit_o - adjusted 4-bit digit
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t digit_i,
   output bcd_digit_t digit_o
);

   always_comb begin
      if (digit_i >= bcd_digit_t'(ADJ_THRESH))
         digit_o = digit_i + bcd_digit_t'(ADJ_ADD);
      else
         digit_o = digit_i;
   end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bcd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv_ctrl
//  Description : Iterative binary-to-BCD converter (shift-and-add-3), one
//                input bit per clock. Accepts a value on start while idle,
//                converts in BIN_W cycles and presents four latched BCD
//                digits plus an overflow flag with a one-cycle done pulse.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - bcd_conv_ctrl_if.slave (start, bin, busy, done,
//                        ONES, TENS, HUNDREDS, TH, ovf)
//  Build macro : BCD_SATURATE_EN - when defined, overflowing results show
//                9999 instead of the value modulo 10000.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_conv_ctrl
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
)(
   input  logic            clk,
   input  logic            rst_n,
   bcd_conv_ctrl_if.slave  bus
);

   state_t              state_q;
   logic [BIN_W-1:0]    shf_q;
   logic [SCR_W-1:0]    scr_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                busy_q;
   logic                done_q;
   logic                ovf_q;
   bcd_digit_t          ones_q;
   bcd_digit_t          tens_q;
   bcd_digit_t          hund_q;
   bcd_digit_t          th_q;

   logic [SCR_W-1:0]       w_adj;
   logic [SCR_W+BIN_W-1:0] w_cat;
   logic [SCR_W-1:0]       w_scr_nxt;
   logic [BIN_W-1:0]       w_shf_nxt;
   logic                   w_ovf;
   bcd_digit_t             w_ones;
   bcd_digit_t             w_tens;
   bcd_digit_t             w_hund;
   bcd_digit_t             w_th;

   // ---------------------------------------------------------------------
   // Per-digit adjust, then the combined {scratch, shift} moves left by one.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scr_q[4*gi +: 4]),
         .digit_o (w_adj[4*gi +: 4])
      );
   end

   assign w_cat     = {w_adj, shf_q} << 1;
   assign w_scr_nxt = w_cat[BIN_W +: SCR_W];
   assign w_shf_nxt = w_cat[BIN_W-1:0];

   // Result as it will look after the final shift; latched on CONV -> DONE
   // so the digits become visible in the same cycle as the done pulse.
   assign w_ovf = (w_scr_nxt[19:16] != 4'd0);

   always_comb begin
      w_ones = w_scr_nxt[3:0];
      w_tens = w_scr_nxt[7:4];
      w_hund = w_scr_nxt[11:8];
      w_th   = w_scr_nxt[15:12];
`ifdef BCD_SATURATE_EN
      if (w_ovf) begin
         w_ones = 4'd9;
         w_tens = 4'd9;
         w_hund = 4'd9;
         w_th   = 4'd9;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // FSM with registered outputs.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shf_q   <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ones_q  <= '0;
         tens_q  <= '0;
         hund_q  <= '0;
         th_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  shf_q   <= bus.bin;
                  scr_q   <= '0;
                  cnt_q   <= CNT_W'(BIN_W);
                  busy_q  <= 1'b1;
                  state_q <= ST_CONV;
               end
            end

            ST_CONV: begin
               scr_q <= w_scr_nxt;
               shf_q <= w_shf_nxt;
               cnt_q <= cnt_q - CNT_W'(1);
               // Counter hits zero with this shift: last bit consumed.
               if (cnt_q == CNT_W'(1)) begin
                  ones_q  <= w_ones;
                  tens_q  <= w_tens;
                  hund_q  <= w_hund;
                  th_q    <= w_th;
                  ovf_q   <= w_ovf;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end

            ST_DONE: begin
               // start here is deliberately not looked at: ignored, not queued.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.ovf      = ovf_q;
   assign bus.ONES     = ones_q;
   assign bus.TENS     = tens_q;
   assign bus.HUNDREDS = hund_q;
   assign bus.TH       = th_q;

endmodule : bcd_conv_ctrl
`default_nettype wire

// File: tb/tb_bcd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_conv_ctrl
//  Description : Directed self-checking bench for bcd_conv_ctrl (BIN_W=14).
//                Expected digit values are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_conv_ctrl;

   localparam int BIN_W = 14;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   cyc;
   int   first_done;
   int   second_done;
   logic [15:0] prev_dig;

   bcd_conv_ctrl_if #(.BIN_W(BIN_W)) bus ();

   bcd_conv_ctrl #(.BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {bus.TH, bus.HUNDREDS, bus.TENS, bus.ONES};
   endfunction

   // Called at a negedge in cycle 0; returns at the negedge of the DONE
   // cycle (cycle BIN_W+1) with start released.
   task automatic run_conv(input string tag, input int b,
                           input logic [15:0] exp_dig, input logic exp_ovf);
      bus.start = 1'b1;
      bus.bin   = BIN_W'(b);
      @(negedge clk);
      bus.start = 1'b0;
      bus.bin   = BIN_W'(~b);   // must not affect the running conversion
      for (int n = 1; n <= BIN_W + 1; n++) begin
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         check({tag, "_done"}, 32'(bus.done), 32'(n == BIN_W + 1));
         if (n < BIN_W + 1) @(negedge clk);
      end
      check({tag, "_digits"}, 32'(digits()), 32'(exp_dig));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      cyc       = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.bin   = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_digits", 32'(digits()), 32'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      // 128 -> 0128
      run_conv("c128", 128, 16'h0128, 1'b0);
      @(negedge clk);
      check("c128_idle_busy", 32'(bus.busy), 32'd0);
      check("c128_idle_done", 32'(bus.done), 32'd0);
      check("c128_hold", 32'(digits()), 32'h0128);

      // Back-to-back 0 then 9999
      run_conv("c0", 0, 16'h0000, 1'b0);
      first_done = cyc;
      @(negedge clk);
      check("b2b_idle_busy", 32'(bus.busy), 32'd0);
      run_conv("c9999", 9999, 16'h9999, 1'b0);
      second_done = cyc;
      check("b2b_spacing", 32'(second_done - first_done), 32'd16);
      @(negedge clk);

      // 12345 -> overflow
`ifdef BCD_SATURATE_EN
      run_conv("c12345", 12345, 16'h9999, 1'b1);
      prev_dig = 16'h9999;
`else
      run_conv("c12345", 12345, 16'h2345, 1'b1);
      prev_dig = 16'h2345;
`endif
      @(negedge clk);

      // start ignored while busy (cycle 5 and the DONE cycle 15)
      bus.start = 1'b1;
      bus.bin   = BIN_W'(128);
      @(negedge clk);
      for (int n = 1; n <= 20; n++) begin
         check("ign_busy", 32'(bus.busy), 32'(n <= BIN_W + 1));
         check("ign_done", 32'(bus.done), 32'(n == BIN_W + 1));
         if (n == 5) check("ign_hold_digits", 32'(digits()), 32'(prev_dig));
         if (n == BIN_W + 1) begin
            check("ign_digits", 32'(digits()), 32'h0128);
            check("ign_ovf", 32'(bus.ovf), 32'd0);
         end
         bus.start = (n == 5 || n == BIN_W + 1);
         bus.bin   = BIN_W'(77);
         @(negedge clk);
      end
      bus.start = 1'b0;

      // 16383 -> overflow, then abort a conversion with reset in cycle 7
`ifdef BCD_SATURATE_EN
      run_conv("c16383", 16383, 16'h9999, 1'b1);
`else
      run_conv("c16383", 16383, 16'h6383, 1'b1);
`endif
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = BIN_W'(500);
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 2; n <= 7; n++) @(negedge clk);
      check("abort_busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_digits", 32'(digits()), 32'h0000);
      check("abort_ovf", 32'(bus.ovf), 32'd0);
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check("abort_no_done", 32'(bus.done), 32'd0);
      end
      run_conv("c42", 42, 16'h0042, 1'b0);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_bcd_conv_ctrl
`default_nettype wire

// File: doc/bcd_conv_ctrl.md
# bcd_conv_ctrl

Sequential binary-to-BCD conversion controller for the frequency counter display path. Accepts a gated count from the measurement logic on a start strobe, runs an iterative shift-and-add-3 (double-dabble) sequence one bit per clock, and presents four latched BCD digits plus an overflow flag to the display multiplexer. It replaces a wide combinational converter with a small resource sequenced by a handshake, and it adds a defined latency.

## Interface
- BIN_W, 14, width of the binary input; legal range 4..16.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  conversion request; sampled only when busy=0.
- bin  in  BIN_W  unsigned value to convert; captured on an accepted start.
- busy  out  1  high while a conversion is in flight, including the done cycle.
- done  out  1  one-cycle pulse; the result outputs update on this cycle.
- ONES, TENS, HUNDREDS, TH  out  4 each  latched BCD digits.
- ovf  out  1  latched; value ≥ 10000 (ten-thousands digit nonzero).

## Operation
- Reset: state=IDLE; busy, done and ovf are 0; all digit outputs are 0; any in-flight conversion is discarded.
- The FSM has three states: IDLE, CONV and DONE.
- IDLE, with start=1:
  - load bin into the shift register;
  - clear the 20-bit scratch register (5 digits);
  - set the bit counter to BIN_W;
  - go to CONV.
- CONV, each cycle:
  - every scratch digit ≥5 gets +3;
  - then {scratch, shift} shifts left by 1;
  - the counter decrements;
  - when the counter reaches 0 after the shift, go to DONE.
- DONE:
  - register the digit outputs and ovf from the scratch register;
  - pulse done;
  - go to IDLE.
- Arithmetic: the scratch register has 5 digits, which covers 2^16−1 = 65535 < 99999. The adjust is applied per 4-bit digit and never carries across digits.
- ovf = (scratch digit 4 ≠ 0).
- Outputs hold their last result until the next DONE. They do not change in IDLE or CONV.
- start while busy=1 is ignored, not queued. This includes start asserted during the DONE cycle.
- A reset during CONV or DONE aborts the conversion. No done pulse is produced and the outputs go to 0.

## Timing
- start is accepted in cycle 0.
- CONV occupies cycles 1..BIN_W.
- DONE and the done pulse are in cycle BIN_W+1; for the default this is cycle 15.
- busy is high for cycles 1..BIN_W+1.
- Back-to-back: start in cycle BIN_W+2 (first IDLE cycle) is accepted. Maximum throughput is one result per BIN_W+2 cycles.
- bin is only sampled in the acceptance cycle, so changes during the conversion have no effect.

## Configuration
- BCD_SATURATE_EN defined: when ovf=1, ONES/TENS/HUNDREDS/TH are forced to 9/9/9/9 in the DONE update.
- BCD_SATURATE_EN undefined: when ovf=1, the low four digits are output unmodified (truncated modulo 10000).
- ovf is reported identically in both builds.

## Structure
- Shared package bcd_pkg holds:
  - the bcd_digit_t 4-bit typedef;
  - the state encodings ST_IDLE, ST_CONV, ST_DONE;
  - NUM_DIGITS = 5;
  - MAX_BIN_W = 16;
  - ADJ_THRESH = 5;
  - ADJ_ADD = 3.
- Sub-module bcd_digit_adj: combinational 4-bit cell, output = in ≥5 ? in+3 : in. It is instantiated NUM_DIGITS times.
- The FSM, counter and shift registers live in the top level.

## Test plan
- bin=128, start pulse → done in cycle 15; TH/HUNDREDS/TENS/ONES = 0/1/2/8, ovf=0; busy high for cycles 1..15.
- bin=0 then bin=9999, issued back-to-back (second start in the first IDLE cycle) → results 0000, then 9999; two done pulses 16 cycles apart; ovf=0 for both.
- bin=12345 → ovf=1. With BCD_SATURATE_EN the digits are 9999; without it they are 2345.
- start at 128, then start with bin=77 at cycles 5 and 15 → both ignored; single result 0128.
- Completed conversion of 16383 (ovf=1), then a new conversion aborted by rst_n=0 in cycle 7 → outputs 0000, ovf=0, busy=0; no done pulse. The next start with bin=42 converts normally to 0042.
